// File: rtl/sop_tt_pkg.sv
// -----------------------------------------------------------------------------
// sop_tt_pkg
// Shared types and width helpers for the programmable truth-table engine.
//   state_e  : sweep controller states (IDLE, SCAN, DONE)
//   tt_w     : truth-table width for a given input count (2^n_in)
//   cnt_w    : minterm-count width for a given input count (n_in+1, so a
//              full table of 2^n_in ones fits without overflow)
//   cnt_off  : bit offset of count field k inside the packed count bus
// -----------------------------------------------------------------------------
package sop_tt_pkg;

    localparam int N_IN_DFLT  = 4;
    localparam int NUM_F_DFLT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int cnt_off(input int k, input int n_in);
        return k * cnt_w(n_in);
    endfunction

endpackage

// File: rtl/sop_tt_lut.sv
// -----------------------------------------------------------------------------
// sop_tt_lut
// Purely combinational read of a bank of NUM_F truth tables at one index.
// Ports:
//   tt_i   : NUM_F packed tables, each 2^N_IN bits (bit i = value at input i)
//   idx_i  : input vector used as the table index
//   f_o    : bit k = tt_i[k][idx_i]
// -----------------------------------------------------------------------------
module sop_tt_lut
    import sop_tt_pkg::*;
#(
    parameter  int N_IN  = N_IN_DFLT,
    parameter  int NUM_F = NUM_F_DFLT,
    localparam int TT_W  = tt_w(N_IN)
) (
    input  logic [NUM_F-1:0][TT_W-1:0] tt_i,
    input  logic [N_IN-1:0]            idx_i,
    output logic [NUM_F-1:0]           f_o
);

    always_comb begin
        for (int k = 0; k < NUM_F; k++) begin
            f_o[k] = tt_i[k][idx_i];
        end
    end

endmodule

// File: rtl/sop_tt_engine.sv
// -----------------------------------------------------------------------------
// sop_tt_engine
// Programmable Boolean-function unit: NUM_F run-time loadable truth tables of
// N_IN inputs, evaluated through a single registered valid/ready stage, plus a
// sweep mode that counts the minterms of every table.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   cfg_we/sel/tt   : table write (honoured only in IDLE, sel < NUM_F)
//   in_valid/ready  : evaluation request handshake, in_vec is the index
//   out_valid/ready : result handshake, out_f bit k = table k at in_vec
//   scan_start      : start a minterm-count sweep (IDLE only)
//   scan_busy       : high while the sweep runs (2^N_IN cycles)
//   scan_done       : one-cycle pulse when scan_count is valid
//   scan_count      : packed counts, field k at cnt_off(k, N_IN)
// -----------------------------------------------------------------------------
module sop_tt_engine
    import sop_tt_pkg::*;
#(
    parameter  int N_IN  = N_IN_DFLT,
    parameter  int NUM_F = NUM_F_DFLT,
    localparam int TT_W  = tt_w(N_IN),
    localparam int CNT_W = cnt_w(N_IN),
    localparam int SEL_W = (NUM_F > 1) ? $clog2(NUM_F) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [SEL_W-1:0]       cfg_sel,
    input  logic [TT_W-1:0]        cfg_tt,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_F-1:0]       out_f,
    input  logic                   scan_start,
    output logic                   scan_busy,
    output logic                   scan_done,
    output logic [NUM_F*CNT_W-1:0] scan_count
);

    state_e                        state_q;
    logic [NUM_F-1:0][TT_W-1:0]    tt_q;
    logic [CNT_W-1:0]              idx_q;
    logic [NUM_F-1:0][CNT_W-1:0]   cnt_q;
    logic [NUM_F-1:0][CNT_W-1:0]   cnt_d;
    logic                          out_valid_q;
    logic [NUM_F-1:0]              out_f_q;
    logic                          scan_busy_q;
    logic                          scan_done_q;

    logic                          accept;
    logic [NUM_F-1:0]              eval_f;
    logic [NUM_F-1:0]              scan_f;

    // Evaluation and sweep read the same registered tables, so a write in the
    // same cycle as an accept is seen only by later evaluations.
    sop_tt_lut #(.N_IN(N_IN), .NUM_F(NUM_F)) u_eval_lut (
        .tt_i  (tt_q),
        .idx_i (in_vec),
        .f_o   (eval_f)
    );

    sop_tt_lut #(.N_IN(N_IN), .NUM_F(NUM_F)) u_scan_lut (
        .tt_i  (tt_q),
        .idx_i (idx_q[N_IN-1:0]),
        .f_o   (scan_f)
    );

    // Requests are only taken in IDLE; the output register may be refilled in
    // the same cycle it drains.
    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        for (int k = 0; k < NUM_F; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(scan_f[k]);
        end
    end

    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        scan_count = '0;
        for (int k = 0; k < NUM_F; k++) begin
            scan_count[cnt_off(k, N_IN) +: CNT_W] = cnt_q[k];
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table bank is a handful of flops, not a RAM, and must
            // read as all-zero after reset, so it is reset like any register.
            tt_q        <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            // Output stage runs independently of the sweep controller so a
            // held result still drains while a sweep is in progress.
            if (accept) begin
                out_f_q     <= eval_f;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            scan_done_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        for (int k = 0; k < NUM_F; k++) begin
                            if (cfg_sel == SEL_W'(k)) begin
                                tt_q[k] <= cfg_tt;
                            end
                        end
                    end
                    if (scan_start) begin
                        state_q     <= SCAN;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        scan_busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    cnt_q <= cnt_d;
                    idx_q <= idx_q + 1'b1;
                    // idx_q is one bit wider than the table index, so the
                    // terminal value is reachable without wrapping.
                    if (idx_q == CNT_W'(TT_W - 1)) begin
                        state_q     <= DONE;
                        scan_busy_q <= 1'b0;
                        scan_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_tt_engine.sv
// -----------------------------------------------------------------------------
// tb_sop_tt_engine
// Scoreboard bench for sop_tt_engine (N_IN=4, NUM_F=2). The stimulus process
// pushes expected results / counts into queues; a negedge monitor pops and
// compares whenever the DUT hands over a result or pulses scan_done.
// -----------------------------------------------------------------------------
module tb_sop_tt_engine;

    localparam int N_IN  = 4;
    localparam int NUM_F = 2;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [0:0]  cfg_sel;
    logic [15:0] cfg_tt;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_f;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [9:0]  scan_count;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    logic [1:0] exp_f_q[$];
    logic [9:0] exp_cnt_q[$];

    sop_tt_engine #(.N_IN(N_IN), .NUM_F(NUM_F)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_tt     (cfg_tt),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .scan_count (scan_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result transfers on the next edge when out_valid&&out_ready
    // at the falling edge; scan_done is compared against queued counts.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_f_q.size() == 0) begin
                    check("unexpected_result", {30'd0, out_f}, 32'hDEAD);
                end else begin
                    check("out_f", {30'd0, out_f}, {30'd0, exp_f_q.pop_front()});
                end
            end
            if (scan_done) begin
                done_pulses++;
                if (exp_cnt_q.size() == 0) begin
                    check("unexpected_scan_done", {22'd0, scan_count}, 32'hDEAD);
                end else begin
                    check("scan_count", {22'd0, scan_count}, {22'd0, exp_cnt_q.pop_front()});
                end
            end
        end
    end

    task automatic eval(input logic [3:0] v, input logic [1:0] exp);
        in_valid = 1'b1;
        in_vec   = v;
        check("in_ready_eval", {31'd0, in_ready}, 32'd1);
        exp_f_q.push_back(exp);
        step();
        in_valid = 1'b0;
    endtask

    task automatic write_tt(input logic sel, input logic [15:0] tt);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_tt  = tt;
        step();
        cfg_we  = 1'b0;
    endtask

    // Runs one sweep; optionally pokes a cfg write and an evaluation request
    // in the middle, both of which must be ignored.
    task automatic run_scan(input logic [9:0] exp_cnt, input bit poke);
        int busy_cycles;
        exp_cnt_q.push_back(exp_cnt);
        scan_start = 1'b1;
        step();
        scan_start  = 1'b0;
        busy_cycles = 0;
        while (scan_busy && busy_cycles < 40) begin
            busy_cycles++;
            if (poke && busy_cycles == 3) begin
                cfg_we   = 1'b1;
                cfg_sel  = 1'b0;
                cfg_tt   = 16'h0000;
                in_valid = 1'b1;
                in_vec   = 4'h0;
                #1;
                check("in_ready_in_scan", {31'd0, in_ready}, 32'd0);
            end
            step();
            cfg_we   = 1'b0;
            in_valid = 1'b0;
        end
        check("scan_busy_cycles", busy_cycles, 32'd16);
        check("scan_done_pulse", {31'd0, scan_done}, 32'd1);
        step();
        check("scan_done_low", {31'd0, scan_done}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_tt     = '0;
        in_valid   = 1'b0;
        in_vec     = '0;
        out_ready  = 1'b1;
        scan_start = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // 1: reset state, evaluation on empty tables, empty sweep
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_f", {30'd0, out_f}, 32'd0);
        check("rst_scan_busy", {31'd0, scan_busy}, 32'd0);
        check("rst_scan_done", {31'd0, scan_done}, 32'd0);
        check("rst_scan_count", {22'd0, scan_count}, 32'd0);
        eval(4'h9, 2'b00);
        check("latency1_valid", {31'd0, out_valid}, 32'd1);
        step();
        run_scan({5'd0, 5'd0}, 1'b0);

        // 2: load tables, back-to-back evaluations
        write_tt(1'b0, 16'h8001);
        write_tt(1'b1, 16'hFFFF);
        in_valid = 1'b1;
        in_vec = 4'h0; exp_f_q.push_back(2'b11); step();
        in_vec = 4'hF; exp_f_q.push_back(2'b11); step();
        check("b2b_out_f_0", {30'd0, out_f}, 32'h3);
        in_vec = 4'h5; exp_f_q.push_back(2'b10); step();
        in_valid = 1'b0;
        check("b2b_out_f_5", {30'd0, out_f}, 32'h2);
        step();
        check("drained", {31'd0, out_valid}, 32'd0);

        // 3: backpressure, then drain and accept in the same cycle
        eval(4'h0, 2'b11);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'h5;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_f_held", {30'd0, out_f}, 32'h3);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        exp_f_q.push_back(2'b10);
        step();
        in_valid = 1'b0;
        check("acc_drain_valid", {31'd0, out_valid}, 32'd1);
        check("acc_drain_out_f", {30'd0, out_f}, 32'h2);
        step();

        // 4: sweep with ignored cfg write / request in the middle
        run_scan({5'd16, 5'd2}, 1'b1);

        // 5: write and evaluate in the same cycle sees the old table
        cfg_we  = 1'b1;
        cfg_sel = 1'b0;
        cfg_tt  = 16'h0000;
        eval(4'h0, 2'b11);
        cfg_we = 1'b0;
        eval(4'h0, 2'b10);
        step();

        // 6: reset during a sweep aborts it
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        repeat (6) step();
        check("mid_scan_busy", {31'd0, scan_busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", {31'd0, scan_busy}, 32'd0);
        check("abort_count", {22'd0, scan_count}, 32'd0);
        check("abort_done", {31'd0, scan_done}, 32'd0);
        eval(4'hF, 2'b00);
        step();
        run_scan({5'd0, 5'd0}, 1'b0);

        repeat (4) step();
        check("results_left", exp_f_q.size(), 32'd0);
        check("counts_left", exp_cnt_q.size(), 32'd0);
        check("done_pulses", done_pulses, 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sop_tt_engine.md
Name: sop_tt_engine

Overview:
- Parametrised, programmable Boolean-function unit. Holds NUM_F truth tables of N_IN inputs each, loaded at run time.
- Evaluates all NUM_F functions on an input vector through a registered valid/ready stage.
- Has a scan mode that sweeps all 2^N_IN input combinations and counts the minterms (ones) of every function.
- Replaces fixed hand-minimised gate netlists: any function is set by its table; the minterm count supports checking those netlists.

Parameters:
- N_IN, 4, number of function inputs (1..8); each table is 2^N_IN bits.
- NUM_F, 2, number of independent output functions (1..16).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  max(1,$clog2(NUM_F))  index of the table to write.
- cfg_tt  in  2^N_IN  new table; bit i is the function value for input vector i.
- in_valid  in  1  evaluation request.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_vec  in  N_IN  input vector; bit N_IN-1 is the MSB variable.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_f  out  NUM_F  bit k = table k indexed by the accepted in_vec.
- scan_start  in  1  request a minterm-count sweep.
- scan_busy  out  1  high while a sweep is in progress.
- scan_done  out  1  one-cycle pulse when the counts are valid.
- scan_count  out  NUM_F*(N_IN+1)  packed counts; field k is bits [k*(N_IN+1) +: N_IN+1].

Behaviour:
- Reset: all tables 0; out_valid=0; out_f=0; scan_busy=0; scan_done=0; scan_count=0; FSM=IDLE; scan index=0.
- A reset mid-sweep aborts the sweep and gives no scan_done pulse.
- Table write: when cfg_we=1 in IDLE, table[cfg_sel] takes cfg_tt at the clock edge.
  - cfg_sel >= NUM_F: ignored.
  - Writes in SCAN or DONE: ignored.
- Evaluation pipeline:
  - One output register. in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - On accept, out_f and out_valid=1 are registered the same edge (latency 1).
  - Table lookup uses the pre-edge table, so an evaluation in the same cycle as a cfg write sees the old table.
  - If out_valid && !out_ready, out_f is held stable.
  - If out_ready=1 with no new accept, out_valid falls.
  - Accept and drain in the same cycle: out_valid stays 1 and out_f is updated.
- FSM states IDLE, SCAN, DONE:
  - IDLE -> SCAN on scan_start. At entry: counts cleared, index=0, scan_busy=1. A result already held in the output register still drains normally.
  - SCAN: each cycle, count[k] += table[k][index] and index increments.
  - SCAN -> DONE after index 2^N_IN-1 is processed (exactly 2^N_IN SCAN cycles). The last increment is included in scan_count at DONE.
  - DONE: scan_done=1 and scan_busy=0 for one cycle, then -> IDLE.
  - scan_start outside IDLE is ignored.
  - scan_start and in_valid together in IDLE: the evaluation is accepted that cycle, then the sweep starts.
- Width rules:
  - Each count is N_IN+1 bits unsigned, so an all-ones table gives 2^N_IN with no overflow.
  - The index is N_IN+1 bits so the terminal compare does not wrap.
  - scan_count holds its value until the next sweep starts.

Decomposition:
- Package sop_tt_pkg:
  - state enum {IDLE, SCAN, DONE};
  - localparams TT_W=2^N_IN and CNT_W=N_IN+1, as functions of N_IN;
  - a helper function for the count field offset.
- One sub-module, sop_tt_lut: purely combinational table-bank read. Given the NUM_F tables and an index, it returns the NUM_F-bit value. It is instanced twice: once for evaluation, once for the scan index.

Test Plan (N_IN=4, NUM_F=2):
1. Reset, then evaluate in_vec=4'h9 -> out_f=2'b00 one cycle later. Then scan -> both counts 0, scan_done after 16 SCAN cycles.
2. Write table0=16'h8001 and table1=16'hFFFF; evaluate 4'h0, 4'hF, 4'h5 back-to-back with out_ready=1 -> out_f = 2'b11, 2'b11, 2'b10 on consecutive cycles.
3. Backpressure: out_ready=0 after the first result -> in_ready=0 and out_f held 2'b11 for 5 cycles. Raising out_ready drains it and accepts the next vector in the same cycle.
4. Scan with the tables from test 2 -> scan_count field0=2 and field1=16 (5'b10000). scan_busy high for 16 cycles, then scan_done pulses once. A cfg write and in_valid during the sweep are ignored (in_ready=0, tables unchanged).
5. cfg_we for table0=16'h0000 in the same cycle as evaluating 4'h0 -> out_f[0]=1 (old table). The next evaluation of 4'h0 gives out_f[0]=0.
6. Assert rst at SCAN cycle 7 -> next cycle scan_busy=0, scan_count=0, tables all 0, no scan_done. A new scan_start then completes normally.
